// File: rtl/ins_seq_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes, FSM states,
// trap causes and the registered strobe bundle.
package ins_seq_ctrl_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned OPC_W    = 7;
   localparam int unsigned RIDX_W   = 5;
   localparam int unsigned CAUSE_W  = 2;

   localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_I_COMP = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_LD     = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_S      = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_B      = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEM    = 3'd3,
      ST_EXEC   = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } seq_state_e;

   typedef enum logic [CAUSE_W-1:0] {
      TRAP_NONE    = 2'd0,
      TRAP_ILLEGAL = 2'd1,
      TRAP_IMEM_TO = 2'd2,
      TRAP_DMEM_TO = 2'd3
   } trap_cause_e;

   typedef struct packed {
      logic imem_req;
      logic ins_latch;
      logic dmem_req;
      logic exec_op;
      logic rf_we;
      logic dmem_we;
      logic halted;
   } seq_strobe_t;

   function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
      case (op)
         OP_R, OP_I_COMP, OP_LD, OP_S, OP_B, OP_JAL, OP_JALR: is_legal_op = 1'b1;
         default:                                             is_legal_op = 1'b0;
      endcase
   endfunction

   function automatic logic is_mem_op(input logic [OPC_W-1:0] op);
      is_mem_op = (op == OP_LD) || (op == OP_S);
   endfunction

endpackage

// File: rtl/ins_seq_timeout.sv
// Loadable down-counter guarding a memory handshake; expired_c flags the last
// permitted wait cycle so an ack arriving in that same cycle can still win.
module ins_seq_timeout #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired_c
);

   localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q;

   // Loaded on entry to the wait state; counts down once per waiting cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign expired_c = en && (cnt_q == '0);

endmodule

// File: rtl/ins_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, memory read, execute strobe
// and write-back commit, one instruction at a time; owns the PC and retire count.
module ins_seq_ctrl
   import ins_seq_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                run,
   output logic                imem_req,
   output logic [XLEN-1:0]     imem_addr,
   input  logic                imem_ack,
   output logic                ins_latch,
   input  logic [OPC_W-1:0]    ins_dec_op,
   input  logic [XLEN-1:0]     reg_rs1_val,
   input  logic [XLEN-1:0]     imm_ext_ext,
   output logic                dmem_req,
   output logic [XLEN-1:0]     dmem_addr,
   input  logic                dmem_ack,
   output logic                exec_op,
   input  logic                x_reg_w_op,
   input  logic [RIDX_W-1:0]   x_reg_w_idx,
   input  logic                x_mem_w_op,
   input  logic                x_pc_w_op,
   input  logic [XLEN-1:0]     x_pc_w_val,
   output logic                rf_we,
   output logic                dmem_we,
   output logic [XLEN-1:0]     pc,
   output logic                halted,
   output logic [CAUSE_W-1:0]  trap_cause,
   output logic [XLEN-1:0]     retired
);

   seq_state_e  state_q, state_n;
   trap_cause_e cause_q, cause_n;
   seq_strobe_t strobe_q, strobe_n;

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] retired_q;
   logic [XLEN-1:0] dmem_addr_q;

   logic imem_load_c;
   logic dmem_load_c;
   logic imem_expired_c;
   logic dmem_expired_c;

   ins_seq_timeout #(.LIMIT(ACK_TIMEOUT)) u_imem_timeout (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .load      (imem_load_c),
      .en        (state_q == ST_FETCH),
      .expired_c (imem_expired_c)
   );

   ins_seq_timeout #(.LIMIT(ACK_TIMEOUT)) u_dmem_timeout (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .load      (dmem_load_c),
      .en        (state_q == ST_MEM),
      .expired_c (dmem_expired_c)
   );

   // Next-state, trap cause and next-cycle strobes; ack is checked before expiry.
   always_comb begin
      state_n     = state_q;
      cause_n     = cause_q;
      strobe_n    = '0;
      imem_load_c = 1'b0;
      dmem_load_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (run) state_n = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               state_n = ST_DECODE;
            end else if (imem_expired_c) begin
               state_n = ST_TRAP;
               cause_n = TRAP_IMEM_TO;
            end
         end
         ST_DECODE: begin
            if (!is_legal_op(ins_dec_op)) begin
               state_n = ST_TRAP;
               cause_n = TRAP_ILLEGAL;
            end else if (is_mem_op(ins_dec_op)) begin
               state_n = ST_MEM;
            end else begin
               state_n = ST_EXEC;
            end
         end
         ST_MEM: begin
            if (dmem_ack) begin
               state_n = ST_EXEC;
            end else if (dmem_expired_c) begin
               state_n = ST_TRAP;
               cause_n = TRAP_DMEM_TO;
            end
         end
         ST_EXEC: begin
            state_n = ST_WB;
         end
         ST_WB: begin
            state_n = run ? ST_FETCH : ST_IDLE;
         end
         ST_TRAP: begin
            state_n = ST_TRAP;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      imem_load_c = (state_n == ST_FETCH) && (state_q != ST_FETCH);
      dmem_load_c = (state_n == ST_MEM) && (state_q != ST_MEM);

      strobe_n.imem_req  = (state_n == ST_FETCH);
      strobe_n.ins_latch = (state_q == ST_FETCH) && (state_n == ST_DECODE);
      strobe_n.dmem_req  = (state_n == ST_MEM);
      strobe_n.exec_op   = (state_n == ST_EXEC);
      // Execute unit results are stable from the negedge of the EXEC cycle.
      strobe_n.rf_we     = (state_n == ST_WB) && x_reg_w_op && (x_reg_w_idx != RIDX_W'(0));
      strobe_n.dmem_we   = (state_n == ST_WB) && x_mem_w_op;
      strobe_n.halted    = (state_n == ST_TRAP);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         cause_q     <= TRAP_NONE;
         strobe_q    <= '0;
         pc_q        <= RESET_PC;
         retired_q   <= '0;
         dmem_addr_q <= '0;
      end else begin
         state_q  <= state_n;
         cause_q  <= cause_n;
         strobe_q <= strobe_n;
         if ((state_q == ST_DECODE) && (state_n == ST_MEM)) begin
            dmem_addr_q <= reg_rs1_val + imm_ext_ext;
         end
         // Architectural commit happens only on leaving WB.
         if (state_q == ST_WB) begin
            pc_q      <= x_pc_w_op ? x_pc_w_val : pc_q + XLEN'(4);
            retired_q <= retired_q + XLEN'(1);
         end
      end
   end

   assign imem_req   = strobe_q.imem_req;
   assign ins_latch  = strobe_q.ins_latch;
   assign dmem_req   = strobe_q.dmem_req;
   assign exec_op    = strobe_q.exec_op;
   assign rf_we      = strobe_q.rf_we;
   assign dmem_we    = strobe_q.dmem_we;
   assign halted     = strobe_q.halted;
   assign trap_cause = CAUSE_W'(cause_q);
   assign pc         = pc_q;
   assign imem_addr  = pc_q;
   assign dmem_addr  = dmem_addr_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_ins_seq_ctrl.sv
// Directed bench for ins_seq_ctrl: plays the memory, decoder and execute unit,
// queues expected commits per instruction and checks them at write-back.
module tb_ins_seq_ctrl;

   localparam int unsigned ACK_TO = 16;
   localparam logic [6:0] T_OP_R    = 7'b0110011;
   localparam logic [6:0] T_OP_LD   = 7'b0000011;
   localparam logic [6:0] T_OP_S    = 7'b0100011;
   localparam logic [6:0] T_OP_B    = 7'b1100011;
   localparam logic [6:0] T_OP_JAL  = 7'b1101111;
   localparam logic [6:0] T_OP_JALR = 7'b1100111;

   logic        sys_clk;
   logic        sys_rst_n;
   logic        run;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        ins_latch;
   logic [6:0]  ins_dec_op;
   logic [31:0] reg_rs1_val;
   logic [31:0] imm_ext_ext;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic        dmem_ack;
   logic        exec_op;
   logic        x_reg_w_op;
   logic [4:0]  x_reg_w_idx;
   logic        x_mem_w_op;
   logic        x_pc_w_op;
   logic [31:0] x_pc_w_val;
   logic        rf_we;
   logic        dmem_we;
   logic [31:0] pc;
   logic        halted;
   logic [1:0]  trap_cause;
   logic [31:0] retired;

   typedef struct {
      logic        rf_we;
      logic        dmem_we;
      logic [31:0] pc;
      logic [31:0] ret;
   } exp_t;

   exp_t        sb_q[$];
   int          total;
   int          bad;
   logic [31:0] exp_pc;
   logic [31:0] exp_ret;
   logic [31:0] frozen_pc;

   ins_seq_ctrl #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(ACK_TO)) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .run         (run),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .ins_latch   (ins_latch),
      .ins_dec_op  (ins_dec_op),
      .reg_rs1_val (reg_rs1_val),
      .imm_ext_ext (imm_ext_ext),
      .dmem_req    (dmem_req),
      .dmem_addr   (dmem_addr),
      .dmem_ack    (dmem_ack),
      .exec_op     (exec_op),
      .x_reg_w_op  (x_reg_w_op),
      .x_reg_w_idx (x_reg_w_idx),
      .x_mem_w_op  (x_mem_w_op),
      .x_pc_w_op   (x_pc_w_op),
      .x_pc_w_val  (x_pc_w_val),
      .rf_we       (rf_we),
      .dmem_we     (dmem_we),
      .pc          (pc),
      .halted      (halted),
      .trap_cause  (trap_cause),
      .retired     (retired)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      imem_ack    = 1'b0;
      dmem_ack    = 1'b0;
      ins_dec_op  = 7'd0;
      reg_rs1_val = 32'd0;
      imm_ext_ext = 32'd0;
      x_reg_w_op  = 1'b0;
      x_reg_w_idx = 5'd0;
      x_mem_w_op  = 1'b0;
      x_pc_w_op   = 1'b0;
      x_pc_w_val  = 32'd0;
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      run       = 1'b0;
      clear_inputs();
      tick();
      sys_rst_n = 1'b1;
      run       = 1'b1;
      exp_pc    = 32'd0;
      exp_ret   = 32'd0;
   endtask

   // Bounded wait for a fetch request.
   task automatic wait_fetch();
      for (int i = 0; i < 8 && !imem_req; i++) tick();
      chk("fetch_req", imem_req, 1);
   endtask

   // Ack the fetch after idly wait cycles; returns in the DECODE cycle.
   task automatic do_fetch(input logic [6:0] op, input int idly);
      for (int i = 0; i < idly; i++) begin
         tick();
      end
      ins_dec_op = op;
      imem_ack   = 1'b1;
      tick();
      imem_ack = 1'b0;
      chk("ins_latch", ins_latch, 1);
   endtask

   // Ack the data read after ddly wait cycles; returns in the EXEC cycle.
   task automatic do_mem(input int ddly, input logic [31:0] exp_addr);
      chk("dmem_req", dmem_req, 1);
      chk("dmem_addr", dmem_addr, exp_addr);
      for (int i = 0; i < ddly; i++) begin
         chk("req_exclusive", {imem_req, dmem_req}, 32'b01);
         tick();
      end
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
   endtask

   task automatic run_instr(input logic [6:0] op, input int idly, input int ddly,
                            input logic [31:0] rs1, input logic [31:0] imm,
                            input logic rw, input logic [4:0] ridx, input logic mw,
                            input logic pw, input logic [31:0] pval, input logic drop_run);
      exp_t e;
      logic is_mem;
      is_mem    = (op == T_OP_LD) || (op == T_OP_S);
      e.rf_we   = rw && (ridx != 5'd0);
      e.dmem_we = mw;
      e.pc      = pw ? pval : exp_pc + 32'd4;
      e.ret     = exp_ret + 32'd1;
      sb_q.push_back(e);

      wait_fetch();
      chk("imem_addr", imem_addr, exp_pc);
      do_fetch(op, idly);
      reg_rs1_val = rs1;
      imm_ext_ext = imm;
      tick();
      if (is_mem) do_mem(ddly, rs1 + imm);
      chk("exec_op", exec_op, 1);
      chk("exec_no_req", {imem_req, dmem_req}, 0);
      x_reg_w_op  = rw;
      x_reg_w_idx = ridx;
      x_mem_w_op  = mw;
      x_pc_w_op   = pw;
      x_pc_w_val  = pval;
      if (drop_run) run = 1'b0;
      tick();
      e = sb_q.pop_front();
      chk("rf_we", rf_we, e.rf_we);
      chk("dmem_we", dmem_we, e.dmem_we);
      chk("exec_op_pulse", exec_op, 0);
      tick();
      chk("pc", pc, e.pc);
      chk("retired", retired, e.ret);
      chk("commit_pulse", {rf_we, dmem_we}, 0);
      exp_pc  = e.pc;
      exp_ret = e.ret;
      clear_inputs();
      if (drop_run) begin
         for (int i = 0; i < 3; i++) begin
            chk("idle_no_fetch", imem_req, 0);
            tick();
         end
         run = 1'b1;
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      exp_pc    = 32'd0;
      exp_ret   = 32'd0;
      sys_rst_n = 1'b0;
      run       = 1'b0;
      clear_inputs();
      #2;
      chk("rst_pc", pc, 32'd0);
      chk("rst_retired", retired, 32'd0);
      chk("rst_cause", trap_cause, 0);
      chk("rst_strobes", {imem_req, ins_latch, dmem_req, exec_op, rf_we, dmem_we, halted}, 0);
      tick();
      do_reset();

      // ADD, LW, SW, BEQ taken, JAL rd=0, boundary acks, JALR with run dropped
      run_instr(T_OP_R,    0,          0, 32'h0,   32'h0, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0,   1'b0);
      run_instr(T_OP_LD,   2,          3, 32'h100, 32'h8, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0,   1'b0);
      run_instr(T_OP_S,    0,          1, 32'h200, 32'h4, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0,   1'b0);
      run_instr(T_OP_B,    1,          0, 32'h0,   32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h40,  1'b0);
      run_instr(T_OP_JAL,  0,          0, 32'h0,   32'h0, 1'b1, 5'd0, 1'b0, 1'b1, 32'h100, 1'b0);
      run_instr(T_OP_LD,   0, ACK_TO - 1, 32'h10,  32'h4, 1'b1, 5'd7, 1'b0, 1'b0, 32'h0,   1'b0);
      run_instr(T_OP_R,   ACK_TO - 1,  0, 32'h0,   32'h0, 1'b1, 5'd9, 1'b0, 1'b0, 32'h0,   1'b0);
      run_instr(T_OP_JALR, 0,          0, 32'h0,   32'h0, 1'b1, 5'd1, 1'b0, 1'b1, 32'h200, 1'b1);
      run_instr(T_OP_R,    0,          0, 32'h0,   32'h0, 1'b1, 5'd2, 1'b0, 1'b0, 32'h0,   1'b0);
      chk("pc_final", pc, 32'h204);
      chk("retired_final", retired, 32'd9);

      // Async reset while waiting in MEM
      wait_fetch();
      do_fetch(T_OP_LD, 0);
      reg_rs1_val = 32'h300;
      tick();
      chk("mem_before_rst", dmem_req, 1);
      sys_rst_n = 1'b0;
      #1;
      chk("rst_mid_dmem_req", dmem_req, 0);
      chk("rst_mid_pc", pc, 32'd0);
      chk("rst_mid_retired", retired, 32'd0);
      chk("rst_mid_commit", {rf_we, dmem_we, exec_op}, 0);
      tick();
      do_reset();

      // imem timeout
      wait_fetch();
      for (int i = 0; i < int'(ACK_TO) - 1; i++) tick();
      chk("imem_wait_last", {halted, imem_req}, 32'b01);
      tick();
      chk("imem_to_halted", halted, 1);
      chk("imem_to_cause", trap_cause, 2);
      chk("imem_to_req", imem_req, 0);
      do_reset();

      // dmem timeout
      wait_fetch();
      do_fetch(T_OP_S, 0);
      tick();
      for (int i = 0; i < int'(ACK_TO) - 1; i++) tick();
      chk("dmem_wait_last", {halted, dmem_req}, 32'b01);
      tick();
      chk("dmem_to_halted", halted, 1);
      chk("dmem_to_cause", trap_cause, 3);
      chk("dmem_to_req", dmem_req, 0);
      do_reset();

      // Illegal opcode after one retired instruction; trap must stay quiet
      run_instr(T_OP_R, 0, 0, 32'h0, 32'h0, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0, 1'b0);
      wait_fetch();
      do_fetch(7'h7F, 0);
      tick();
      chk("ill_halted", halted, 1);
      chk("ill_cause", trap_cause, 1);
      frozen_pc = exp_pc;
      for (int i = 0; i < 100; i++) begin
         imem_ack   = 1'($urandom);
         dmem_ack   = 1'($urandom);
         x_reg_w_op = 1'($urandom);
         x_reg_w_idx = 5'd3;
         x_mem_w_op = 1'($urandom);
         tick();
         chk("trap_quiet", {imem_req, ins_latch, dmem_req, exec_op, rf_we, dmem_we}, 0);
         chk("trap_pc", pc, frozen_pc);
      end
      chk("trap_retired", retired, 32'd1);
      chk("sb_empty", 32'(sb_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
